bit_serial_addsub: RTL

Sequential N-bit two's-complement adder/subtractor that processes operands LSB-first, one bit per clock.
Each step is one full-adder cell with a registered carry, the same single-bit add/subtract cell as the team's 1-bit adder_subtractor.
It accepts a request with operands and opcode, iterates N cycles, then returns sum, carry-out and signed overflow with a one-cycle done pulse.
Serves as the area-minimal arithmetic unit for the datapath.

---
 rtl/bit_serial_addsub.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bit_serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell with a
// registered carry, operands consumed LSB-first, one bit per clock.
module bit_serial_addsub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         sub_i,
    input  logic         cin_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic         cout_o,
    output logic         ovf_o
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a request transfers on a rising edge where start_i=1 and
    // ready_o=1; start_i at any other time is dropped, nothing is queued.
    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [N-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic sum_bit;
    logic carry_nx;
    logic last_bit;

    assign sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last_bit = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == S_IDLE);
        busy_o  = (state_q == S_RUN);
        done_o  = (state_q == S_DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // Subtract is a + ~b + ~borrow_in.
                    a_d     = a_i;
                    b_d     = sub_i ? ~b_i : b_i;
                    carry_d = cin_i ^ sub_i;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_nx;
                cnt_d   = cnt_q + CW'(1);
                sr_d    = {sum_bit, sr_q[N-1:1]};
                if (last_bit) begin
                    result_d = {sum_bit, sr_q[N-1:1]};
                    cout_d   = carry_nx;
                    ovf_d    = carry_q ^ carry_nx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sr_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;

endmodule
